// File: rtl/banked_memory.sv
// rtl/banked_memory.sv - multi-bank synchronous RAM with byte-masked writes,
// registered bank select on the read path, and a clear-all init sequencer
module banked_memory #(
  parameter int NUM_BANKS       = 4,
  parameter int BANK_ADDR_WIDTH = 14,
  parameter int DATA_WIDTH      = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int BANK_SEL_WIDTH = $clog2(NUM_BANKS),
  localparam int ADDR_WIDTH     = BANK_SEL_WIDTH + BANK_ADDR_WIDTH,
  localparam int MASK_WIDTH     = DATA_WIDTH / 8,
  localparam int DEPTH          = 1 << BANK_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [MASK_WIDTH-1:0]     req_wmask,
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [BANK_SEL_WIDTH-1:0] rsp_bank,
  output logic                      init_done
);

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]                state_q, state_d;
  logic [BANK_ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [BANK_SEL_WIDTH-1:0] rsp_bank_q, rsp_bank_d;
  logic [DATA_WIDTH-1:0]     rd_data_q [NUM_BANKS];
  logic [DATA_WIDTH-1:0]     rd_data_d [NUM_BANKS];

  logic [DATA_WIDTH-1:0]     mem [NUM_BANKS][DEPTH];

  logic [BANK_SEL_WIDTH-1:0]  req_bank;
  logic [BANK_ADDR_WIDTH-1:0] req_local;
  logic                       in_init;
  logic                       accept;
  logic [BANK_ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]      wr_data;
  logic [MASK_WIDTH-1:0]      wr_mask;
  logic [NUM_BANKS-1:0]       wr_en;

  assign req_bank  = req_addr[ADDR_WIDTH-1 -: BANK_SEL_WIDTH];
  assign req_local = req_addr[BANK_ADDR_WIDTH-1:0];
  assign in_init   = (state_q == ST_INIT);
  assign accept    = req_valid && (state_q == ST_READY);

  // During INIT every bank is swept in parallel with a full mask
  assign wr_addr = in_init ? cnt_q : req_local;
  assign wr_data = in_init ? INIT_VALUE : req_wdata;
  assign wr_mask = in_init ? {MASK_WIDTH{1'b1}} : req_wmask;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (in_init) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == BANK_ADDR_WIDTH'(DEPTH - 1)) begin
        state_d = ST_READY;
      end
    end
    // A request accepted alongside clear still completes; clear wins the state
    if (clear) begin
      state_d = ST_INIT;
      cnt_d   = '0;
    end
  end

  always_comb begin
    rsp_valid_d = accept && !req_we;
    rsp_bank_d  = rsp_valid_d ? req_bank : rsp_bank_q;
    for (int b = 0; b < NUM_BANKS; b++) begin
      wr_en[b]     = in_init || (accept && req_we && (req_bank == BANK_SEL_WIDTH'(b)));
      rd_data_d[b] = rd_data_q[b];
      if (accept && !req_we && (req_bank == BANK_SEL_WIDTH'(b))) begin
        rd_data_d[b] = mem[b][req_local];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (wr_en[b]) begin
          for (int i = 0; i < MASK_WIDTH; i++) begin
            if (wr_mask[i]) begin
              mem[b][wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_bank_q  <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        rd_data_q[b] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_bank_q  <= rsp_bank_d;
      for (int b = 0; b < NUM_BANKS; b++) begin
        rd_data_q[b] <= rd_data_d[b];
      end
    end
  end

  // Output mux keys off the registered bank, so idle cycles hold the last word
  assign rsp_rdata = rd_data_q[rsp_bank_q];
  assign rsp_valid = rsp_valid_q;
  assign rsp_bank  = rsp_bank_q;
  assign req_ready = (state_q == ST_READY);
  assign init_done = (state_q == ST_READY);

endmodule
